dram_bank_array_bfm: RTL
========================

# dram_bank_array_bfm

Parametrised, cycle-accurate behavioural model of a multi-bank DRAM device with per-bank row buffers, activate/precharge timing and a fixed CAS read latency. It sits in the testbench below the DRAM controller under test. It accepts one command per cycle, models open-row state per bank, and flags protocol violations. It supersedes the single-bit, fixed-8-bank model with separate read/write data paths and configurable geometry.

## Interface
- NUM_OF_BANKS, 8, bank count (power of two, ≥2)
- NUM_OF_ROWS, 128, rows per bank (power of two)
- NUM_OF_COLS, 8, columns per row (power of two)
- DATA_WIDTH, 8, bits per column word
- CAS_LAT, 2, RD-to-rdata_valid latency in cycles (≥1)
- T_RCD, 3, ACT-to-RD/WR delay in cycles (≥1)
- T_RP, 2, PRE-to-ACT delay in cycles (≥1)
- T_RFC, 8, refresh busy time in cycles (≥1, used only with refresh)

- clk  in  1  sole clock, rising-edge
- rst  in  1  synchronous, active-high reset
- cmd  in  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF, others illegal
- bank_id  in  $clog2(NUM_OF_BANKS)  target bank
- rowid  in  $clog2(NUM_OF_ROWS)  row, used by ACT
- colid  in  $clog2(NUM_OF_COLS)  column, used by RD/WR
- wdata  in  DATA_WIDTH  write data, sampled with WR
- rdata  out  DATA_WIDTH  read data, valid only while rdata_valid
- rdata_valid  out  1  single-cycle read data strobe
- bank_open  out  NUM_OF_BANKS  bit b high while bank b is ACTIVE
- err  out  1  one-cycle pulse, the command sampled on the previous edge was illegal and was ignored

## Operation
- Storage: NUM_OF_BANKS×NUM_OF_ROWS×NUM_OF_COLS words, plus one NUM_OF_COLS-word row buffer and open-row register per bank.
- Per-bank FSM states: IDLE, ACTIVATING, ACTIVE, PRECHARGING. Reset state is IDLE.
- IDLE + ACT: copy row rowid into the bank row buffer, latch the open row, load the counter with T_RCD, and go to ACTIVATING.
- ACTIVATING: decrement the counter each cycle. At zero, go to ACTIVE.
- ACTIVE + RD: read the row buffer at colid and push it into the CAS_LAT-deep read pipeline.
- ACTIVE + WR: write wdata into the row buffer at colid on the same edge.
- ACTIVE + PRE: write the row buffer back to the open row on the same edge, load T_RP, and go to PRECHARGING.
- PRECHARGING: count down to zero, then go to IDLE.
- Legal no-ops: PRE to an IDLE bank; NOP.
- Illegal, ignored with err:
  - ACT to a non-IDLE bank
  - RD/WR to a non-ACTIVE bank
  - any command to a bank in ACTIVATING or PRECHARGING, except NOP
  - illegal opcode
- Read pipeline: independent of bank state. PRE issued while a read is in flight does not disturb the returned data.
- RD followed by WR to the same column: the RD returns the old value. WR followed by RD: the RD returns the new value.

## Timing
- Reset values: rdata=0, rdata_valid=0, bank_open=0, err=0. All banks IDLE, counters 0, read pipeline empty, array and row buffers zeroed. Reset asserted mid-operation aborts in-flight reads; no rdata_valid follows.
- ACT at edge n: RD/WR is legal at edge n+T_RCD. bank_open[b] rises after edge n+T_RCD.
- RD at edge n: rdata_valid is high and rdata is valid for the cycle following edge n+CAS_LAT. Back-to-back RDs give back-to-back strobes.
- PRE at edge n: bank_open[b] falls after edge n. ACT is legal at edge n+T_RP.
- err is registered: high for the cycle after the offending edge.

## Configuration
- DRAM_BFM_REFRESH_EN defined:
  - REF (101) is legal only when every bank is IDLE; otherwise err.
  - Accepted REF puts the device busy for T_RFC cycles. Every command other than NOP during that window gives err.
  - Array contents are unchanged by REF.
- DRAM_BFM_REFRESH_EN undefined: 101 is an illegal opcode, giving err and no state change. T_RFC is unused.

## Test plan
- Reset, then ACT b0 r5, wait 3, WR c2 0xA5, RD c2 -> rdata=0xA5 with rdata_valid exactly 2 cycles after RD; bank_open=0x01.
- WR b3 r7 c1 0x3C, PRE, wait 2, ACT r9, ACT-wait, RD c1 -> 0x00; PRE, ACT r7, RD c1 -> 0x3C (writeback verified).
- ACT b1, then RD b1 one cycle later -> err pulse, no rdata_valid; ACT b1 again while ACTIVE -> err.
- Banks 0 and 7 open concurrently; interleaved RDs on consecutive cycles -> two consecutive valid strobes with the correct per-bank data.
- RD issued, rst asserted the next cycle -> rdata_valid never asserts, bank_open=0, a subsequent read of the prior location returns 0.
- With DRAM_BFM_REFRESH_EN: REF with a bank open -> err; REF all-IDLE, ACT 3 cycles later -> err, ACT at T_RFC -> accepted. Without the macro: REF -> err.

Source files
------------

// File: rtl/dram_bank_array_bfm.sv
// Cycle-accurate multi-bank DRAM model: per-bank row buffers, ACT/PRE timing, fixed CAS read latency.
// Optional refresh support is enabled by defining DRAM_BFM_REFRESH_EN.
module dram_bank_array_bfm #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int CAS_LAT      = 2,
  parameter int T_RCD        = 3,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2:0]                      cmd,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  rowid,
  input  logic [$clog2(NUM_OF_COLS)-1:0]  colid,
  input  logic [DATA_WIDTH-1:0]           wdata,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            rdata_valid,
  output logic [NUM_OF_BANKS-1:0]         bank_open,
  output logic                            err
);

  localparam int BW    = $clog2(NUM_OF_BANKS);
  localparam int RW    = $clog2(NUM_OF_ROWS);
  localparam int CW    = $clog2(NUM_OF_COLS);
  localparam int DEPTH = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
  localparam int TMAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int RFC_W = $clog2(T_RFC + 1);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_ACTIVATING  = 2'd1;
  localparam logic [1:0] S_ACTIVE      = 2'd2;
  localparam logic [1:0] S_PRECHARGING = 2'd3;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b001;
  localparam logic [2:0] CMD_RD  = 3'b010;
  localparam logic [2:0] CMD_WR  = 3'b011;
  localparam logic [2:0] CMD_PRE = 3'b100;
  localparam logic [2:0] CMD_REF = 3'b101;

  logic [1:0]            state    [NUM_OF_BANKS];
  logic [TW-1:0]         cnt      [NUM_OF_BANKS];
  logic [RW-1:0]         open_row [NUM_OF_BANKS];
  logic [DATA_WIDTH-1:0] row_buf  [NUM_OF_BANKS][NUM_OF_COLS];
  logic [DATA_WIDTH-1:0] mem      [DEPTH];
  logic                  pipe_v   [CAS_LAT];
  logic [DATA_WIDTH-1:0] pipe_d   [CAS_LAT];
  logic [RFC_W-1:0]      ref_cnt;

  logic [NUM_OF_BANKS-1:0] eff_idle;
  logic [NUM_OF_BANKS-1:0] eff_active;
  logic                    ref_busy;
  logic                    legal;

  // A bank whose countdown expires on this edge already behaves as its destination state.
  always_comb begin
    eff_idle   = '0;
    eff_active = '0;
    bank_open  = '0;
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      eff_idle[b]   = (state[b] == S_IDLE) ||
                      ((state[b] == S_PRECHARGING) && (cnt[b] == TW'(1)));
      eff_active[b] = (state[b] == S_ACTIVE) ||
                      ((state[b] == S_ACTIVATING) && (cnt[b] == TW'(1)));
      bank_open[b]  = (state[b] == S_ACTIVE);
    end
    ref_busy = (ref_cnt > RFC_W'(1));
  end

  always_comb begin
    legal = 1'b0;
    case (cmd)
      CMD_NOP: legal = 1'b1;
      CMD_ACT: legal = eff_idle[bank_id];
      CMD_RD,
      CMD_WR:  legal = eff_active[bank_id];
      CMD_PRE: legal = eff_idle[bank_id] | eff_active[bank_id];
`ifdef DRAM_BFM_REFRESH_EN
      CMD_REF: legal = &eff_idle;
`endif
      default: legal = 1'b0;
    endcase
    if (ref_busy && (cmd != CMD_NOP)) legal = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        state[b]    <= S_IDLE;
        cnt[b]      <= '0;
        open_row[b] <= '0;
        for (int c = 0; c < NUM_OF_COLS; c++) row_buf[b][c] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int k = 0; k < CAS_LAT; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_d[k] <= '0;
      end
      ref_cnt     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= ~legal;
      if (ref_cnt != '0) ref_cnt <= ref_cnt - RFC_W'(1);

      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        if ((state[b] == S_ACTIVATING) || (state[b] == S_PRECHARGING)) begin
          cnt[b] <= cnt[b] - TW'(1);
          if (cnt[b] == TW'(1))
            state[b] <= (state[b] == S_ACTIVATING) ? S_ACTIVE : S_IDLE;
        end
      end

      pipe_v[0] <= 1'b0;
      pipe_d[0] <= '0;
      for (int k = 1; k < CAS_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
      rdata_valid <= pipe_v[CAS_LAT-1];
      rdata       <= pipe_d[CAS_LAT-1];

      // Command effects are written last so they override the countdown update above.
      if (legal) begin
        case (cmd)
          CMD_ACT: begin
            for (int c = 0; c < NUM_OF_COLS; c++)
              row_buf[bank_id][c] <= mem[{bank_id, rowid, CW'(c)}];
            open_row[bank_id] <= rowid;
            cnt[bank_id]      <= TW'(T_RCD);
            state[bank_id]    <= S_ACTIVATING;
          end
          CMD_RD: begin
            pipe_v[0] <= 1'b1;
            pipe_d[0] <= row_buf[bank_id][colid];
          end
          CMD_WR: row_buf[bank_id][colid] <= wdata;
          CMD_PRE: begin
            if (eff_active[bank_id]) begin
              for (int c = 0; c < NUM_OF_COLS; c++)
                mem[{bank_id, open_row[bank_id], CW'(c)}] <= row_buf[bank_id][c];
              cnt[bank_id]   <= TW'(T_RP);
              state[bank_id] <= S_PRECHARGING;
            end
          end
`ifdef DRAM_BFM_REFRESH_EN
          CMD_REF: ref_cnt <= RFC_W'(T_RFC);
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
